// File: rtl/debug_display_pkg.sv
// rtl/debug_display_pkg.sv - shared helpers and key indices for the debug display controller
package debug_display_pkg;

    localparam int KEY_CH  = 0;
    localparam int KEY_PG  = 1;
    localparam int KEY_FRZ = 2;

    // Bit width able to index n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of display windows needed to cover a data_w-bit word
    function automatic int NPAGES_F(input int data_w, input int digits);
        return (data_w + 4 * digits - 1) / (4 * digits);
    endfunction

endpackage

// File: rtl/debug_display_if.sv
// rtl/debug_display_if.sv - channel data, keys and display signals between core side and controller
interface debug_display_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int DIGITS = 6
);
    import debug_display_pkg::*;

    localparam int CH_W   = clog2_min1(N_CH);
    localparam int NPAGES = NPAGES_F(DATA_W, DIGITS);
    localparam int PG_W   = clog2_min1(NPAGES);

    logic [N_CH*DATA_W-1:0] ch_data;
    logic [2:0]             key_n;
    logic [4*DIGITS-1:0]    disp_val;
    logic [DIGITS-1:0]      digit_blank;
    logic [CH_W-1:0]        ch_sel;
    logic [PG_W-1:0]        page_sel;
    logic                   frozen;

    modport master (
        output ch_data, key_n,
        input  disp_val, digit_blank, ch_sel, page_sel, frozen
    );

    modport slave (
        input  ch_data, key_n,
        output disp_val, digit_blank, ch_sel, page_sel, frozen
    );

endinterface

// File: rtl/debug_display_key_debounce.sv
// rtl/debug_display_key_debounce.sv - pushbutton synchroniser, debouncer and press-edge detector
module key_debounce
    import debug_display_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int                CNT_W   = clog2_min1(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while the synced level disagrees with the accepted one
    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_MAX) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accepted level starts as "pressed" so a key held through reset stays locked out
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulse in the cycle the accepted level moves from released to pressed
    assign press = reset && acc_q && !acc_d;

endmodule

// File: rtl/debug_display_ctrl.sv
// rtl/debug_display_ctrl.sv - debug word viewer with channel/page navigation; optional SNAPSHOT_EN freeze view
module debug_display_ctrl
    import debug_display_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 32,
    parameter int DIGITS       = 6,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic           clock,
    input  logic           reset,
    debug_display_if.slave dbg
);

    localparam int CH_W   = clog2_min1(N_CH);
    localparam int NPAGES = NPAGES_F(DATA_W, DIGITS);
    localparam int PG_W   = clog2_min1(NPAGES);
    localparam int WIN_W  = 4 * DIGITS;
    localparam int PAD_W  = NPAGES * WIN_W;

    logic              press_ch, press_pg;
    logic              frozen_s;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PG_W-1:0]   pg_q, pg_d;
    logic [DATA_W-1:0] src;
    logic [PAD_W-1:0]  pad;
    logic [WIN_W-1:0]  disp_q, disp_d;
    logic [DIGITS-1:0] blank_q, blank_d;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ch (
        .clock (clock),
        .reset (reset),
        .key_n (dbg.key_n[KEY_CH]),
        .press (press_ch)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pg (
        .clock (clock),
        .reset (reset),
        .key_n (dbg.key_n[KEY_PG]),
        .press (press_pg)
    );

`ifdef SNAPSHOT_EN
    logic              press_frz;
    logic              frz_q;
    logic [DATA_W-1:0] snap_q [N_CH];

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_frz (
        .clock (clock),
        .reset (reset),
        .key_n (dbg.key_n[KEY_FRZ]),
        .press (press_frz)
    );

    // Freeze toggles; entering freeze captures every channel, leaving it keeps the snapshot
    always_ff @(posedge clock) begin
        if (!reset) begin
            frz_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) snap_q[i] <= '0;
        end else if (press_frz) begin
            frz_q <= !frz_q;
            if (!frz_q) begin
                for (int i = 0; i < N_CH; i++) snap_q[i] <= dbg.ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign frozen_s = frz_q;
`else
    logic unused_frz_key;
    assign unused_frz_key = dbg.key_n[KEY_FRZ];
    assign frozen_s       = 1'b0;
`endif

    // Channel step wraps and rewinds the page; a simultaneous page press loses
    always_comb begin
        ch_d = ch_q;
        pg_d = pg_q;
        if (press_ch && (N_CH > 1)) begin
            ch_d = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
            pg_d = '0;
        end else if (press_pg && (NPAGES > 1)) begin
            pg_d = (pg_q == PG_W'(NPAGES - 1)) ? '0 : pg_q + PG_W'(1);
        end
    end

    // Select the live or frozen word, zero-extend it to whole pages and cut out the current window
    always_comb begin
        src = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
`ifdef SNAPSHOT_EN
                src = frozen_s ? snap_q[i] : dbg.ch_data[i*DATA_W +: DATA_W];
`else
                src = dbg.ch_data[i*DATA_W +: DATA_W];
`endif
            end
        end
        pad              = '0;
        pad[DATA_W-1:0]  = src;
        disp_d           = '0;
        for (int p = 0; p < NPAGES; p++) begin
            if (pg_q == PG_W'(p)) disp_d = pad[p*WIN_W +: WIN_W];
        end
        for (int d = 0; d < DIGITS; d++) begin
            blank_d[d] = ((int'(pg_q) * DIGITS + d) * 4 >= DATA_W);
        end
    end

    // Navigation state and registered display outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            ch_q    <= '0;
            pg_q    <= '0;
            disp_q  <= '0;
            blank_q <= '0;
        end else begin
            ch_q    <= ch_d;
            pg_q    <= pg_d;
            disp_q  <= disp_d;
            blank_q <= blank_d;
        end
    end

    assign dbg.ch_sel      = ch_q;
    assign dbg.page_sel    = pg_q;
    assign dbg.disp_val    = disp_q;
    assign dbg.digit_blank = blank_q;
    assign dbg.frozen      = frozen_s;

endmodule
